// File: rtl/layer_sequencer.sv
// layer_sequencer: walks the neural datapath through a multi-layer network,
// one instruction-RAM descriptor per layer, ping-ponging neuron RAM regions.
module layer_sequencer #(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned LAYER_W      = 3,
    parameter int unsigned NEURO_BASE_A = 0,
    parameter int unsigned NEURO_BASE_B = 10,
    parameter int unsigned TIMEOUT_W    = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [LAYER_W-1:0] num_layers,
    output logic [LAYER_W-1:0] instr_addr,
    input  logic [15:0]        instr_data,
    output logic               ag_reset,
    output logic               ag_read,
    output logic [7:0]         ag_nk,
    input  logic               ag_finished,
    output logic [ADDR_W-1:0]  read_weight_base,
    output logic [ADDR_W-1:0]  read_neuro_base,
    output logic [ADDR_W-1:0]  write_neuro_base,
    output logic               mac_clear,
    output logic               busy,
    output logic               done,
    output logic               error
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned PROD_W = 2 * CNT_W;
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(NEURO_BASE_A);
    localparam logic [ADDR_W-1:0] BASE_B = ADDR_W'(NEURO_BASE_B);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_PRIME,
        S_RUN,
        S_NEXT,
        S_DONE,
        S_ERROR
    } state_e;

    state_e               state_q, state_d;
    logic [LAYER_W-1:0]   layer_q, layer_d;
    logic [LAYER_W-1:0]   nlayers_q, nlayers_d;
    logic [CNT_W-1:0]     n_in_q, n_in_d;
    logic [CNT_W-1:0]     n_out_q, n_out_d;
    logic [ADDR_W-1:0]    wbase_q, wbase_d;
    logic [ADDR_W-1:0]    rbase_q, rbase_d;
    logic [ADDR_W-1:0]    wrbase_q, wrbase_d;
    logic [TIMEOUT_W-1:0] wd_q, wd_d;
    logic                 prime_q, prime_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;
    logic                 ag_reset_q, ag_reset_d;
    logic                 ag_read_q, ag_read_d;
    logic                 mac_clear_q, mac_clear_d;
    logic [PROD_W-1:0]    layer_prod;

    // Weight words consumed by the current layer.
    assign layer_prod = PROD_W'(n_in_q) * PROD_W'(n_out_q);

    // Next-state, datapath updates and registered-output decode.
    always_comb begin
        state_d     = state_q;
        layer_d     = layer_q;
        nlayers_d   = nlayers_q;
        n_in_d      = n_in_q;
        n_out_d     = n_out_q;
        wbase_d     = wbase_q;
        rbase_d     = rbase_q;
        wrbase_d    = wrbase_q;
        wd_d        = wd_q;
        prime_d     = prime_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        error_d     = 1'b0;
        ag_reset_d  = 1'b0;
        ag_read_d   = 1'b0;
        mac_clear_d = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE, S_ERROR: state_d = state_q;
                S_FETCH: begin
                    n_in_d  = instr_data[15:8];
                    n_out_d = instr_data[7:0];
                    prime_d = 1'b0;
                    if ((instr_data[15:8] == '0) || (instr_data[7:0] == '0)) begin
                        state_d = S_NEXT;
                    end else begin
                        state_d = S_PRIME;
                    end
                end
                S_PRIME: begin
                    wd_d    = '0;
                    prime_d = 1'b1;
                    if (prime_q) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    wd_d = wd_q + TIMEOUT_W'(1);
                    if (ag_finished) begin
                        state_d = S_NEXT;
                    end else if (&wd_d) begin
                        state_d = S_ERROR;
                    end
                end
                S_NEXT: begin
                    wbase_d  = wbase_q + ADDR_W'(layer_prod);
                    rbase_d  = wrbase_q;
                    wrbase_d = rbase_q;
                    if (layer_q == (nlayers_q - LAYER_W'(1))) begin
                        state_d = S_DONE;
                    end else begin
                        layer_d = layer_q + LAYER_W'(1);
                        state_d = S_FETCH;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase

            // A start is only honoured while no network is in flight.
            if (start && (state_q inside {S_IDLE, S_DONE, S_ERROR})) begin
                nlayers_d = num_layers;
                if (num_layers == '0) begin
                    state_d = S_DONE;
                end else begin
                    state_d  = S_FETCH;
                    layer_d  = '0;
                    wbase_d  = '0;
                    rbase_d  = BASE_A;
                    wrbase_d = BASE_B;
                end
            end
        end

        busy_d      = state_d inside {S_FETCH, S_PRIME, S_RUN, S_NEXT};
        done_d      = (state_d == S_DONE);
        error_d     = (state_d == S_ERROR);
        ag_read_d   = (state_d == S_PRIME);
        mac_clear_d = (state_d == S_PRIME);
        ag_reset_d  = abort || (state_d inside {S_FETCH, S_ERROR});
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            layer_q     <= '0;
            nlayers_q   <= '0;
            n_in_q      <= '0;
            n_out_q     <= '0;
            wbase_q     <= '0;
            rbase_q     <= BASE_A;
            wrbase_q    <= BASE_B;
            wd_q        <= '0;
            prime_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            ag_reset_q  <= 1'b0;
            ag_read_q   <= 1'b0;
            mac_clear_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            layer_q     <= layer_d;
            nlayers_q   <= nlayers_d;
            n_in_q      <= n_in_d;
            n_out_q     <= n_out_d;
            wbase_q     <= wbase_d;
            rbase_q     <= rbase_d;
            wrbase_q    <= wrbase_d;
            wd_q        <= wd_d;
            prime_q     <= prime_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            ag_reset_q  <= ag_reset_d;
            ag_read_q   <= ag_read_d;
            mac_clear_q <= mac_clear_d;
        end
    end

    assign instr_addr       = layer_q;
    assign ag_nk            = n_out_q;
    assign read_weight_base = wbase_q;
    assign read_neuro_base  = rbase_q;
    assign write_neuro_base = wrbase_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign error            = error_q;
    assign ag_reset         = ag_reset_q;
    assign ag_read          = ag_read_q;
    assign mac_clear        = mac_clear_q;

endmodule
